// File: rtl/reg_file_wb_arbiter.sv
// Register file write-back arbiter: merges ALU and load-unit results into the single
// register file write port. Each source is buffered in a 2-entry FIFO; ALU has fixed
// priority, and the load unit is forced through after STARVE_MAX lost cycles.
// Optional build macro WB_LOAD_EXT_EN: sign/zero-extend load data at FIFO push.
module reg_file_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              wb_in_clk,
    input  logic              wb_in_rstL,
    input  logic              alu_in_valid,
    input  logic [ADDR_W-1:0] alu_in_waddr,
    input  logic [DATA_W-1:0] alu_in_wdata,
    output logic              alu_out_ready,
    input  logic              lsu_in_valid,
    input  logic [ADDR_W-1:0] lsu_in_waddr,
    input  logic [DATA_W-1:0] lsu_in_rdata,
    input  logic [1:0]        lsu_in_size,
    input  logic              lsu_in_signed,
    output logic              lsu_out_ready,
    output logic              wb_out_we,
    output logic [ADDR_W-1:0] wb_out_waddr,
    output logic [DATA_W-1:0] wb_out_wdata,
    output logic [31:0]       wb_out_busy_mask,
    output logic [7:0]        wb_out_drop_cnt
);

    localparam int unsigned StW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    // Per-source FIFO state
    logic [ADDR_W-1:0] alu_addr_q [2];
    logic [DATA_W-1:0] alu_data_q [2];
    logic              alu_wptr_q, alu_wptr_d, alu_rptr_q, alu_rptr_d;
    logic [1:0]        alu_cnt_q, alu_cnt_d;
    logic [ADDR_W-1:0] lsu_addr_q [2];
    logic [DATA_W-1:0] lsu_data_q [2];
    logic              lsu_wptr_q, lsu_wptr_d, lsu_rptr_q, lsu_rptr_d;
    logic [1:0]        lsu_cnt_q, lsu_cnt_d;

    logic [StW-1:0]    starve_q, starve_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    logic [7:0]        drop_q, drop_d;

    logic              alu_push, lsu_push, alu_pop, lsu_pop;
    logic              alu_ne, lsu_ne;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [DATA_W-1:0] lsu_push_data;

    // One-hot register bit for busy tracking; r0 is never marked busy.
    function automatic logic [31:0] addr_bit(input logic [ADDR_W-1:0] a);
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) begin
            if (a == ADDR_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

`ifdef WB_LOAD_EXT_EN
    // Extend load data according to access size before it is buffered.
    always_comb begin
        lsu_push_data = lsu_in_rdata;
        unique case (lsu_in_size)
            2'b00: lsu_push_data = {{(DATA_W-8){lsu_in_signed & lsu_in_rdata[7]}},
                                    lsu_in_rdata[7:0]};
            2'b01: lsu_push_data = {{(DATA_W-16){lsu_in_signed & lsu_in_rdata[15]}},
                                    lsu_in_rdata[15:0]};
            default: lsu_push_data = lsu_in_rdata;
        endcase
    end
`else
    logic unused_ext;
    assign unused_ext    = ^{lsu_in_size, lsu_in_signed};
    assign lsu_push_data = lsu_in_rdata;
`endif

    // Ready reflects the registered count only: no pop-to-push bypass.
    assign alu_out_ready = ~wb_in_rstL & (alu_cnt_q != 2'd2);
    assign lsu_out_ready = ~wb_in_rstL & (lsu_cnt_q != 2'd2);
    assign alu_push      = alu_in_valid & alu_out_ready;
    assign lsu_push      = lsu_in_valid & lsu_out_ready;
    assign alu_ne        = (alu_cnt_q != 2'd0);
    assign lsu_ne        = (lsu_cnt_q != 2'd0);

    // Arbitration over FIFO heads, starvation tracking and output-stage next state.
    always_comb begin
        alu_pop    = 1'b0;
        lsu_pop    = 1'b0;
        starve_d   = starve_q;
        win        = 1'b0;
        win_addr   = '0;
        win_data   = '0;
        if (lsu_ne && (!alu_ne || starve_q == StW'(STARVE_MAX))) begin
            lsu_pop  = 1'b1;
            win      = 1'b1;
            win_addr = lsu_addr_q[lsu_rptr_q];
            win_data = lsu_data_q[lsu_rptr_q];
        end else if (alu_ne) begin
            alu_pop  = 1'b1;
            win      = 1'b1;
            win_addr = alu_addr_q[alu_rptr_q];
            win_data = alu_data_q[alu_rptr_q];
        end
        if (!lsu_ne || lsu_pop) begin
            starve_d = '0;
        end else if (alu_pop) begin
            starve_d = starve_q + 1'b1;
        end

        // Writes to r0 are consumed but never reach the register file.
        wb_we_d    = win && (win_addr != '0);
        wb_waddr_d = wb_we_d ? win_addr : wb_waddr_q;
        wb_wdata_d = wb_we_d ? win_data : wb_wdata_q;
        drop_d     = drop_q;
        if (win && (win_addr == '0) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

        alu_wptr_d = alu_wptr_q ^ alu_push;
        alu_rptr_d = alu_rptr_q ^ alu_pop;
        alu_cnt_d  = alu_cnt_q + {1'b0, alu_push} - {1'b0, alu_pop};
        lsu_wptr_d = lsu_wptr_q ^ lsu_push;
        lsu_rptr_d = lsu_rptr_q ^ lsu_pop;
        lsu_cnt_d  = lsu_cnt_q + {1'b0, lsu_push} - {1'b0, lsu_pop};
    end

    // Control state with synchronous reset; buffered entries are discarded on reset.
    always_ff @(posedge wb_in_clk) begin
        if (wb_in_rstL) begin
            alu_wptr_q <= 1'b0;
            alu_rptr_q <= 1'b0;
            alu_cnt_q  <= 2'd0;
            lsu_wptr_q <= 1'b0;
            lsu_rptr_q <= 1'b0;
            lsu_cnt_q  <= 2'd0;
            starve_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            drop_q     <= 8'd0;
        end else begin
            alu_wptr_q <= alu_wptr_d;
            alu_rptr_q <= alu_rptr_d;
            alu_cnt_q  <= alu_cnt_d;
            lsu_wptr_q <= lsu_wptr_d;
            lsu_rptr_q <= lsu_rptr_d;
            lsu_cnt_q  <= lsu_cnt_d;
            starve_q   <= starve_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            drop_q     <= drop_d;
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset needed.
    always_ff @(posedge wb_in_clk) begin
        if (alu_push) begin
            alu_addr_q[alu_wptr_q] <= alu_in_waddr;
            alu_data_q[alu_wptr_q] <= alu_in_wdata;
        end
        if (lsu_push) begin
            lsu_addr_q[lsu_wptr_q] <= lsu_in_waddr;
            lsu_data_q[lsu_wptr_q] <= lsu_push_data;
        end
    end

    // Busy mask: every destination held in a FIFO or presented on the write port.
    always_comb begin
        wb_out_busy_mask = '0;
        if (alu_cnt_q != 2'd0) wb_out_busy_mask |= addr_bit(alu_addr_q[alu_rptr_q]);
        if (alu_cnt_q == 2'd2) wb_out_busy_mask |= addr_bit(alu_addr_q[~alu_rptr_q]);
        if (lsu_cnt_q != 2'd0) wb_out_busy_mask |= addr_bit(lsu_addr_q[lsu_rptr_q]);
        if (lsu_cnt_q == 2'd2) wb_out_busy_mask |= addr_bit(lsu_addr_q[~lsu_rptr_q]);
        if (wb_we_q)           wb_out_busy_mask |= addr_bit(wb_waddr_q);
        if (wb_in_rstL)        wb_out_busy_mask = '0;
    end

    assign wb_out_we       = wb_we_q;
    assign wb_out_waddr    = wb_waddr_q;
    assign wb_out_wdata    = wb_wdata_q;
    assign wb_out_drop_cnt = drop_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed self-checking bench for reg_file_wb_arbiter.
module tb_reg_file_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_size;
    logic        lsu_signed;
    logic        lsu_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic [7:0]  drop;

    int n_vec = 0;
    int n_err = 0;

    reg_file_wb_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .STARVE_MAX(3)
    ) dut (
        .wb_in_clk       (clk),
        .wb_in_rstL      (rst),
        .alu_in_valid    (alu_valid),
        .alu_in_waddr    (alu_waddr),
        .alu_in_wdata    (alu_wdata),
        .alu_out_ready   (alu_ready),
        .lsu_in_valid    (lsu_valid),
        .lsu_in_waddr    (lsu_waddr),
        .lsu_in_rdata    (lsu_rdata),
        .lsu_in_size     (lsu_size),
        .lsu_in_signed   (lsu_signed),
        .lsu_out_ready   (lsu_ready),
        .wb_out_we       (we),
        .wb_out_waddr    (waddr),
        .wb_out_wdata    (wdata),
        .wb_out_busy_mask(busy),
        .wb_out_drop_cnt (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({we, waddr, wdata, drop} !== 46'd0) begin
            n_err++;
            $display("FAIL reset_regs: we=%0b waddr=%0d wdata=%h drop=%0d, want all 0",
                     we, waddr, wdata, drop);
        end
        n_vec++;
        if ({alu_ready, lsu_ready, busy} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_ready_busy: readys=%b%b busy=%h, want 0 0 0",
                     alu_ready, lsu_ready, busy);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({alu_ready, lsu_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL post_reset_ready: got %b%b want 11", alu_ready, lsu_ready);
        end
    endtask

    task automatic test_single();
        alu_valid = 1'b1;
        alu_waddr = 5'd5;
        alu_wdata = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        n_vec++;
        if (we !== 1'b0 || busy !== 32'h0000_0020) begin
            n_err++;
            $display("FAIL single_c1: we=%0b busy=%h, want we=0 busy=00000020", we, busy);
        end
        tick();
        n_vec++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234_5678 ||
            busy !== 32'h0000_0020) begin
            n_err++;
            $display("FAIL single_c2: we=%0b waddr=%0d wdata=%h busy=%h, want 1 5 12345678 00000020",
                     we, waddr, wdata, busy);
        end
        tick();
        n_vec++;
        if (we !== 1'b0 || busy !== 32'h0) begin
            n_err++;
            $display("FAIL single_c3: we=%0b busy=%h, want 0 0", we, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1'b1;
            alu_waddr = 5'(i);
            alu_wdata = 32'h11 * i;
            n_vec++;
            if (alu_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %0b want 1", i, alu_ready);
            end
            tick();
            if (i > 1) begin
                n_vec++;
                if (we !== 1'b1 || waddr !== 5'(i - 1) || wdata !== 32'h11 * (i - 1)) begin
                    n_err++;
                    $display("FAIL b2b_out[%0d]: we=%0b waddr=%0d wdata=%h want 1 %0d %h",
                             i - 1, we, waddr, wdata, i - 1, 32'h11 * (i - 1));
                end
            end
        end
        alu_valid = 1'b0;
        tick();
        n_vec++;
        if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin
            n_err++;
            $display("FAIL b2b_out[3]: we=%0b waddr=%0d wdata=%h want 1 3 33", we, waddr, wdata);
        end
        tick();
        n_vec++;
        if (we !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: we=%0b want 0", we);
        end
    endtask

    // Both sources held valid: grants settle into ALU,ALU,ALU,LSU.
    task automatic test_starvation();
        logic        exp_lsu;
        logic        exp_rdy;
        alu_valid  = 1'b1;
        alu_waddr  = 5'd10;
        alu_wdata  = 32'hAAAA_0001;
        lsu_valid  = 1'b1;
        lsu_waddr  = 5'd20;
        lsu_rdata  = 32'hBBBB_0002;
        lsu_size   = 2'b10;
        lsu_signed = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            tick();
            exp_rdy = !(n >= 5 && ((n - 1) % 4) == 0);
            n_vec++;
            if (alu_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL starve_alu_ready@edge%0d: got %0b want %0b", n, alu_ready, exp_rdy);
            end
            if (n >= 2) begin
                exp_lsu = ((n - 1) % 4) == 0;
                n_vec++;
                if (we !== 1'b1 || waddr !== (exp_lsu ? 5'd20 : 5'd10) ||
                    wdata !== (exp_lsu ? 32'hBBBB_0002 : 32'hAAAA_0001)) begin
                    n_err++;
                    $display("FAIL starve_grant@edge%0d: we=%0b waddr=%0d wdata=%h want lsu=%0b",
                             n, we, waddr, wdata, exp_lsu);
                end
            end
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (we !== 1'b0 || busy !== 32'h0) begin
            n_err++;
            $display("FAIL starve_drain: we=%0b busy=%h want 0 0", we, busy);
        end
    endtask

    task automatic test_r0();
        int saw_we;
        alu_valid = 1'b1;
        alu_waddr = 5'd0;
        alu_wdata = 32'hFFFF_FFFF;
        tick();
        alu_valid = 1'b0;
        n_vec++;
        if (busy !== 32'h0 || drop !== 8'd0) begin
            n_err++;
            $display("FAIL r0_c1: busy=%h drop=%0d want 0 0", busy, drop);
        end
        tick();
        n_vec++;
        if (we !== 1'b0 || drop !== 8'd1) begin
            n_err++;
            $display("FAIL r0_drop1: we=%0b drop=%0d want 0 1", we, drop);
        end
        saw_we = 0;
        alu_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (we !== 1'b0) saw_we++;
        end
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (saw_we != 0 || drop !== 8'd255) begin
            n_err++;
            $display("FAIL r0_saturate: we_cycles=%0d drop=%0d want 0 255", saw_we, drop);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd   [6];
        logic [1:0]  sz   [6];
        logic        sg   [6];
        logic [31:0] expv [6];
        rd[0] = 32'h0000_0080; sz[0] = 2'b00; sg[0] = 1'b1;
        rd[1] = 32'h0000_0080; sz[1] = 2'b00; sg[1] = 1'b0;
        rd[2] = 32'h0000_8001; sz[2] = 2'b01; sg[2] = 1'b1;
        rd[3] = 32'h0000_0080; sz[3] = 2'b10; sg[3] = 1'b1;
        rd[4] = 32'hDEAD_BEEF; sz[4] = 2'b11; sg[4] = 1'b1;
        rd[5] = 32'hABCD_1280; sz[5] = 2'b00; sg[5] = 1'b0;
`ifdef WB_LOAD_EXT_EN
        expv[0] = 32'hFFFF_FF80;
        expv[1] = 32'h0000_0080;
        expv[2] = 32'hFFFF_8001;
        expv[3] = 32'h0000_0080;
        expv[4] = 32'hDEAD_BEEF;
        expv[5] = 32'h0000_0080;
`else
        expv[0] = 32'h0000_0080;
        expv[1] = 32'h0000_0080;
        expv[2] = 32'h0000_8001;
        expv[3] = 32'h0000_0080;
        expv[4] = 32'hDEAD_BEEF;
        expv[5] = 32'hABCD_1280;
`endif
        for (int i = 0; i < 6; i++) begin
            lsu_valid  = 1'b1;
            lsu_waddr  = 5'd7;
            lsu_rdata  = rd[i];
            lsu_size   = sz[i];
            lsu_signed = sg[i];
            tick();
            lsu_valid = 1'b0;
            tick();
            n_vec++;
            if (we !== 1'b1 || waddr !== 5'd7 || wdata !== expv[i]) begin
                n_err++;
                $display("FAIL load_ext[%0d]: we=%0b waddr=%0d wdata=%h want 1 7 %h",
                         i, we, waddr, wdata, expv[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int saw_we;
        alu_valid  = 1'b1;
        alu_waddr  = 5'd10;
        alu_wdata  = 32'hAAAA_0001;
        lsu_valid  = 1'b1;
        lsu_waddr  = 5'd20;
        lsu_rdata  = 32'hBBBB_0002;
        lsu_size   = 2'b10;
        lsu_signed = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({alu_ready, lsu_ready, busy} !== 34'd0) begin
            n_err++;
            $display("FAIL midrst_during: readys=%b%b busy=%h want 0 0 0",
                     alu_ready, lsu_ready, busy);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        n_vec++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1 || busy !== 32'h0 || we !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_after: readys=%b%b busy=%h we=%0b want 11 0 0",
                     alu_ready, lsu_ready, busy, we);
        end
        saw_we = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (we !== 1'b0 || busy !== 32'h0) saw_we++;
        end
        n_vec++;
        if (saw_we != 0) begin
            n_err++;
            $display("FAIL midrst_no_write: %0d cycles with we/busy set, want 0", saw_we);
        end
    endtask

    initial begin
        rst        = 1'b1;
        alu_valid  = 1'b0;
        alu_waddr  = '0;
        alu_wdata  = '0;
        lsu_valid  = 1'b0;
        lsu_waddr  = '0;
        lsu_rdata  = '0;
        lsu_size   = 2'b10;
        lsu_signed = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_starvation();
        test_r0();
        test_load_ext();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
